// File: rtl/tqvp_uart_pkg.sv
// Shared UART definitions used by the receiver and its downstream byte buffer.
package tqvp_uart_pkg;

    // Default byte width carried between the receiver and the buffer.
    localparam int UART_PAYLOAD_BITS  = 8;

    // Default receive buffer depth exponent (2**2 = 4 entries).
    localparam int RX_FIFO_DEPTH_LOG2 = 2;

    // What the receive buffer does with the receiver's byte this cycle.
    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,   // nothing offered, or capture blocked
        RX_PUSH  = 2'd1,   // store the byte and acknowledge it
        RX_DROP  = 2'd2,   // acknowledge and discard (buffer full)
        RX_STALL = 2'd3    // buffer full, leave the receiver holding its byte
    } rx_action_e;

    // A level counter must represent 0..2**depth_log2 inclusive.
    function automatic int level_width(input int depth_log2);
        return depth_log2 + 1;
    endfunction

endpackage

// File: rtl/tqvp_sync_fifo.sv
// Generic single-clock FIFO with first-word-fall-through read data,
// free-running wrap-around pointers and a separate occupancy counter.
module tqvp_sync_fifo
    import tqvp_uart_pkg::*;
#(
    parameter int WIDTH      = UART_PAYLOAD_BITS,
    parameter int DEPTH_LOG2 = RX_FIFO_DEPTH_LOG2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic                  pop,
    input  logic                  flush,
    input  logic [WIDTH-1:0]      wr_data,
    output logic [WIDTH-1:0]      rd_data,
    output logic [DEPTH_LOG2:0]   level,
    output logic [DEPTH_LOG2:0]   level_next,
    output logic                  empty,
    output logic                  full
);

    localparam int DEPTH   = 1 << DEPTH_LOG2;
    localparam int LEVEL_W = level_width(DEPTH_LOG2);
    localparam logic [LEVEL_W-1:0]    LEVEL_MAX = LEVEL_W'(DEPTH);
    localparam logic [LEVEL_W-1:0]    LEVEL_ONE = LEVEL_W'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = DEPTH_LOG2'(1);

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wptr_reg;
    logic [DEPTH_LOG2-1:0] rptr_reg;
    logic [LEVEL_W-1:0]    level_reg;
    logic                  do_push;
    logic                  do_pop;

    assign empty   = (level_reg == '0);
    assign full    = (level_reg == LEVEL_MAX);

    // Guard locally so the FIFO can never over/underflow whatever the caller does.
    assign do_push = push & ~full  & ~flush;
    assign do_pop  = pop  & ~empty & ~flush;

    // Head entry is visible without a read strobe.
    assign rd_data = mem[rptr_reg];
    assign level   = level_reg;

    // Next occupancy; also consumed by the parent for registered status flags.
    always_comb begin
        level_next = level_reg;
        if (flush) begin
            level_next = '0;
        end else begin
            case ({do_push, do_pop})
                2'b10:   level_next = level_reg + LEVEL_ONE;
                2'b01:   level_next = level_reg - LEVEL_ONE;
                default: level_next = level_reg;
            endcase
        end
    end

    // Storage write; contents are deliberately left unreset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr_reg] <= wr_data;
        end
    end

    // Pointer and occupancy state; flush behaves like a soft reset.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wptr_reg  <= '0;
            rptr_reg  <= '0;
            level_reg <= '0;
        end else begin
            if (do_push) begin
                wptr_reg <= wptr_reg + PTR_ONE;
            end
            if (do_pop) begin
                rptr_reg <= rptr_reg + PTR_ONE;
            end
            level_reg <= level_next;
        end
    end

endmodule

// File: rtl/tqvp_uart_rx_fifo.sv
// Receive-side byte buffer behind the UART receiver: drains completed bytes
// via the receiver's valid/read handshake into a FWFT FIFO and reports
// level, overrun and a threshold interrupt.
module tqvp_uart_rx_fifo
    import tqvp_uart_pkg::*;
#(
    parameter int PAYLOAD_BITS   = UART_PAYLOAD_BITS,
    parameter int DEPTH_LOG2     = RX_FIFO_DEPTH_LOG2,
    parameter int DROP_WHEN_FULL = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rx_valid,
    input  logic [PAYLOAD_BITS-1:0] rx_data,
    output logic                    rx_read,
    input  logic                    rd_en,
    output logic [PAYLOAD_BITS-1:0] rd_data,
    output logic                    rd_valid,
    output logic [DEPTH_LOG2:0]     level,
    output logic                    full,
    output logic                    overrun,
    input  logic                    clr_overrun,
    input  logic                    flush,
    input  logic [DEPTH_LOG2:0]     irq_thresh,
    output logic                    irq
);

    logic               rx_read_reg;
    logic               overrun_reg;
    logic               irq_reg;
    logic               fifo_empty;
    logic               fifo_full;
    logic [DEPTH_LOG2:0] level_next;
    logic               accept;
    logic               push;
    logic               drop;
    logic               pop;
    rx_action_e         rx_action;

    // The receiver still shows valid during the ack cycle, so ignore it then
    // to avoid capturing the same byte twice.
    assign accept = rx_valid & ~rx_read_reg & ~flush;

    // Decide what to do with the offered byte this cycle.
    always_comb begin
        rx_action = RX_IDLE;
        if (accept) begin
            if (!fifo_full) begin
                rx_action = RX_PUSH;
            end else if (DROP_WHEN_FULL != 0) begin
                rx_action = RX_DROP;
            end else begin
                rx_action = RX_STALL;
            end
        end
    end

    assign push = (rx_action == RX_PUSH);
    assign drop = (rx_action == RX_DROP);
    assign pop  = rd_en & ~fifo_empty & ~flush;

    tqvp_sync_fifo #(
        .WIDTH      (PAYLOAD_BITS),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .pop        (pop),
        .flush      (flush),
        .wr_data    (rx_data),
        .rd_data    (rd_data),
        .level      (level),
        .level_next (level_next),
        .empty      (fifo_empty),
        .full       (fifo_full)
    );

    // One-cycle acknowledge, issued the cycle after a byte is taken or dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_read_reg <= 1'b0;
        end else begin
            rx_read_reg <= push | drop;
        end
    end

    // Sticky overrun: flush clears, a drop beats a simultaneous clear.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            overrun_reg <= 1'b0;
        end else if (drop) begin
            overrun_reg <= 1'b1;
        end else if (clr_overrun) begin
            overrun_reg <= 1'b0;
        end
    end

    // Threshold interrupt from the next-state level so it tracks the level register.
    always_ff @(posedge clk) begin
        if (rst) begin
            irq_reg <= 1'b0;
        end else begin
            irq_reg <= (irq_thresh != '0) && (level_next >= irq_thresh);
        end
    end

    assign rx_read  = rx_read_reg;
    assign overrun  = overrun_reg;
    assign irq      = irq_reg;
    assign rd_valid = ~fifo_empty;
    assign full     = fifo_full;

endmodule

// File: tb/tb_tqvp_uart_rx_fifo.sv
// Directed bench for tqvp_uart_rx_fifo: a back-pressure instance (a_*) is
// driven from a per-cycle vector table, and both it and a drop-when-full
// instance (b_*) get hand-written multi-cycle sequences.
module tb_tqvp_uart_rx_fifo;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rd_en;
    logic       flush;
    logic       clr_overrun;
    logic [2:0] irq_thresh;

    logic       a_rx_read, a_rd_valid, a_full, a_overrun, a_irq;
    logic [7:0] a_rd_data;
    logic [2:0] a_level;
    logic       b_rx_read, b_rd_valid, b_full, b_overrun, b_irq;
    logic [7:0] b_rd_data;
    logic [2:0] b_level;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    tqvp_uart_rx_fifo #(.PAYLOAD_BITS(8), .DEPTH_LOG2(2), .DROP_WHEN_FULL(0)) dut_a (
        .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data), .rx_read(a_rx_read),
        .rd_en(rd_en), .rd_data(a_rd_data), .rd_valid(a_rd_valid), .level(a_level),
        .full(a_full), .overrun(a_overrun), .clr_overrun(clr_overrun), .flush(flush),
        .irq_thresh(irq_thresh), .irq(a_irq)
    );

    tqvp_uart_rx_fifo #(.PAYLOAD_BITS(8), .DEPTH_LOG2(2), .DROP_WHEN_FULL(1)) dut_b (
        .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data), .rx_read(b_rx_read),
        .rd_en(rd_en), .rd_data(b_rd_data), .rd_valid(b_rd_valid), .level(b_level),
        .full(b_full), .overrun(b_overrun), .clr_overrun(clr_overrun), .flush(flush),
        .irq_thresh(irq_thresh), .irq(b_irq)
    );

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic       rd;
        logic       fl;
        logic [2:0] th;
        logic       rv;
        logic [7:0] rdat;
        logic [2:0] lvl;
        logic       ack;
        logic       full;
        logic       irq;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(input logic v, input logic [7:0] d, input logic rd,
                                input logic fl, input logic [2:0] th, input logic rv,
                                input logic [7:0] rdat, input logic [2:0] lvl,
                                input logic ack, input logic full, input logic irq);
        vec_t r;
        r.v = v; r.d = d; r.rd = rd; r.fl = fl; r.th = th;
        r.rv = rv; r.rdat = rdat; r.lvl = lvl; r.ack = ack; r.full = full; r.irq = irq;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; rd_en = 1'b0; flush = 1'b0; clr_overrun = 1'b0; irq_thresh = 3'd0;
        rx_valid = 1'b1; rx_data = 8'hEE;   // must be ignored while in reset
        tick();
        tick();
        rx_valid = 1'b0;
        rst = 1'b0;
    endtask

    // Plays the receiver: hold the byte until acknowledged, then one more cycle.
    task automatic send(input logic [7:0] b, input bit use_b);
        bit got;
        got = 1'b0;
        rx_valid = 1'b1;
        rx_data  = b;
        for (int i = 0; i < 20 && !got; i++) begin
            tick();
            if (use_b ? b_rx_read : a_rx_read) got = 1'b1;
        end
        chk("send_ack", 32'(got), 32'd1);
        tick();
        chk("ack_single", 32'(use_b ? b_rx_read : a_rx_read), 32'd0);
        rx_valid = 1'b0;
    endtask

    initial begin
        logic [7:0] q[$];

        // --------------------------- reset state ---------------------------
        do_reset();
        chk("rst_rd_valid", 32'(a_rd_valid), 32'd0);
        chk("rst_level",    32'(a_level),    32'd0);
        chk("rst_rx_read",  32'(a_rx_read),  32'd0);
        chk("rst_irq",      32'(a_irq),      32'd0);
        chk("rst_full",     32'(a_full),     32'd0);
        chk("rst_overrun",  32'(b_overrun),  32'd0);

        // ---------------- per-cycle vectors on the back-pressure instance ----------------
        //            v  d      rd fl th   rv rdat   lvl ack full irq
        vq.push_back(mk(0, 8'h00, 0, 0, 0,  0, 8'h00, 0,  0,  0,  0)); // idle
        vq.push_back(mk(1, 8'hA5, 0, 0, 0,  1, 8'hA5, 1,  1,  0,  0)); // capture A5
        vq.push_back(mk(1, 8'hA5, 0, 0, 0,  1, 8'hA5, 1,  0,  0,  0)); // still valid in ack cycle
        vq.push_back(mk(0, 8'h00, 1, 0, 0,  0, 8'h00, 0,  0,  0,  0)); // pop
        vq.push_back(mk(1, 8'h01, 0, 0, 0,  1, 8'h01, 1,  1,  0,  0));
        vq.push_back(mk(1, 8'h01, 0, 0, 0,  1, 8'h01, 1,  0,  0,  0));
        vq.push_back(mk(1, 8'h02, 0, 0, 0,  1, 8'h01, 2,  1,  0,  0));
        vq.push_back(mk(1, 8'h02, 0, 0, 0,  1, 8'h01, 2,  0,  0,  0));
        vq.push_back(mk(1, 8'h03, 0, 0, 0,  1, 8'h01, 3,  1,  0,  0));
        vq.push_back(mk(1, 8'h03, 0, 0, 0,  1, 8'h01, 3,  0,  0,  0));
        vq.push_back(mk(1, 8'h04, 0, 0, 0,  1, 8'h01, 4,  1,  1,  0)); // now full
        vq.push_back(mk(1, 8'h04, 0, 0, 0,  1, 8'h01, 4,  0,  1,  0));
        vq.push_back(mk(1, 8'h05, 0, 0, 0,  1, 8'h01, 4,  0,  1,  0)); // stalled, no ack
        vq.push_back(mk(1, 8'h05, 0, 0, 0,  1, 8'h01, 4,  0,  1,  0));
        vq.push_back(mk(1, 8'h05, 1, 0, 0,  1, 8'h02, 3,  0,  0,  0)); // pop, no bypass
        vq.push_back(mk(1, 8'h05, 0, 0, 0,  1, 8'h02, 4,  1,  1,  0)); // 05 captured
        vq.push_back(mk(1, 8'h05, 0, 0, 0,  1, 8'h02, 4,  0,  1,  0));
        vq.push_back(mk(0, 8'h00, 1, 0, 0,  1, 8'h03, 3,  0,  0,  0));
        vq.push_back(mk(0, 8'h00, 1, 0, 0,  1, 8'h04, 2,  0,  0,  0));
        vq.push_back(mk(0, 8'h00, 1, 0, 0,  1, 8'h05, 1,  0,  0,  0));
        vq.push_back(mk(0, 8'h00, 1, 0, 0,  0, 8'h00, 0,  0,  0,  0));
        vq.push_back(mk(0, 8'h00, 1, 0, 0,  0, 8'h00, 0,  0,  0,  0)); // pop while empty
        vq.push_back(mk(1, 8'h11, 0, 0, 3,  1, 8'h11, 1,  1,  0,  0)); // irq threshold 3
        vq.push_back(mk(1, 8'h11, 0, 0, 3,  1, 8'h11, 1,  0,  0,  0));
        vq.push_back(mk(1, 8'h12, 0, 0, 3,  1, 8'h11, 2,  1,  0,  0));
        vq.push_back(mk(1, 8'h12, 0, 0, 3,  1, 8'h11, 2,  0,  0,  0));
        vq.push_back(mk(1, 8'h13, 0, 0, 3,  1, 8'h11, 3,  1,  0,  1)); // irq with third byte
        vq.push_back(mk(1, 8'h13, 0, 0, 3,  1, 8'h11, 3,  0,  0,  1));
        vq.push_back(mk(0, 8'h00, 1, 0, 3,  1, 8'h12, 2,  0,  0,  0)); // below threshold
        vq.push_back(mk(1, 8'h14, 0, 0, 3,  1, 8'h12, 3,  1,  0,  1));
        vq.push_back(mk(1, 8'h14, 0, 0, 3,  1, 8'h12, 3,  0,  0,  1));
        vq.push_back(mk(1, 8'h15, 0, 1, 3,  0, 8'h00, 0,  0,  0,  0)); // flush blocks capture
        vq.push_back(mk(1, 8'h15, 0, 0, 3,  1, 8'h15, 1,  1,  0,  0)); // captured after flush
        vq.push_back(mk(1, 8'h15, 0, 0, 3,  1, 8'h15, 1,  0,  0,  0));
        vq.push_back(mk(0, 8'h00, 1, 0, 3,  0, 8'h00, 0,  0,  0,  0));
        vq.push_back(mk(1, 8'h21, 1, 0, 0,  1, 8'h21, 1,  1,  0,  0)); // empty push + rd_en
        vq.push_back(mk(1, 8'h21, 0, 0, 0,  1, 8'h21, 1,  0,  0,  0));
        vq.push_back(mk(0, 8'h00, 1, 0, 0,  0, 8'h00, 0,  0,  0,  0));

        foreach (vq[i]) begin
            rx_valid = vq[i].v; rx_data = vq[i].d; rd_en = vq[i].rd;
            flush = vq[i].fl; irq_thresh = vq[i].th;
            tick();
            chk($sformatf("vec%0d_rd_valid", i), 32'(a_rd_valid), 32'(vq[i].rv));
            chk($sformatf("vec%0d_level", i),    32'(a_level),    32'(vq[i].lvl));
            chk($sformatf("vec%0d_rx_read", i),  32'(a_rx_read),  32'(vq[i].ack));
            chk($sformatf("vec%0d_full", i),     32'(a_full),     32'(vq[i].full));
            chk($sformatf("vec%0d_irq", i),      32'(a_irq),      32'(vq[i].irq));
            chk($sformatf("vec%0d_overrun", i),  32'(a_overrun),  32'd0);
            if (vq[i].rv) chk($sformatf("vec%0d_rd_data", i), 32'(a_rd_data), 32'(vq[i].rdat));
        end
        rx_valid = 1'b0; rd_en = 1'b0; flush = 1'b0; irq_thresh = 3'd0;

        // ---------------- pointer wrap with simultaneous push+pop at level 2 ----------------
        do_reset();
        send(8'h50, 1'b0); q.push_back(8'h50);
        send(8'h51, 1'b0); q.push_back(8'h51);
        chk("wrap_start_level", 32'(a_level), 32'd2);
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("wrap%0d_head", i), 32'(a_rd_data), 32'(q[0]));
            rx_valid = 1'b1; rx_data = 8'(8'h60 + i); rd_en = 1'b1;
            tick();
            void'(q.pop_front());
            q.push_back(8'(8'h60 + i));
            chk($sformatf("wrap%0d_ack", i),   32'(a_rx_read), 32'd1);
            chk($sformatf("wrap%0d_level", i), 32'(a_level),   32'd2);
            rd_en = 1'b0;                       // ack cycle: receiver still valid
            tick();
            chk($sformatf("wrap%0d_hold", i),  32'(a_level),   32'd2);
        end
        rx_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("wrap_drain%0d", i), 32'(a_rd_data), 32'(q[0]));
            void'(q.pop_front());
            rd_en = 1'b1;
            tick();
            rd_en = 1'b0;
        end
        chk("wrap_end_level", 32'(a_level), 32'd0);

        // ---------------- drop-when-full instance ----------------
        do_reset();
        for (int i = 0; i < 4; i++) send(8'(8'h31 + i), 1'b1);
        chk("drop_full",  32'(b_full),  32'd1);
        chk("drop_level", 32'(b_level), 32'd4);
        rx_valid = 1'b1; rx_data = 8'h66;
        tick();
        chk("drop_ack",     32'(b_rx_read), 32'd1);
        chk("drop_overrun", 32'(b_overrun), 32'd1);
        chk("drop_level4",  32'(b_level),   32'd4);
        rx_valid = 1'b0;
        tick();
        chk("drop_ack_single", 32'(b_rx_read), 32'd0);
        rx_valid = 1'b1; rx_data = 8'h77; clr_overrun = 1'b1;   // drop and clear together
        tick();
        chk("drop_clr_ack",     32'(b_rx_read), 32'd1);
        chk("drop_clr_overrun", 32'(b_overrun), 32'd1);
        rx_valid = 1'b0; clr_overrun = 1'b0;
        tick();
        clr_overrun = 1'b1;
        tick();
        clr_overrun = 1'b0;
        chk("clr_overrun", 32'(b_overrun), 32'd0);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("drop_data%0d", i), 32'(b_rd_data), 32'(8'h31 + i));
            rd_en = 1'b1;
            tick();
            rd_en = 1'b0;
        end
        chk("drop_drained", 32'(b_rd_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Safety net so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/tqvp_uart_rx_fifo.md
Name: tqvp_uart_rx_fifo

Overview:
Receive-side byte buffer placed directly downstream of the UART receiver. It drains each completed byte from the receiver's valid/read handshake into a small FIFO and presents first-word-fall-through data to the peripheral register interface. It also provides level, overrun and threshold-interrupt status. Its read-acknowledge output drives the receiver's read input, which in turn gates the receiver's RTS.

Parameters:
PAYLOAD_BITS, 8, data bits per byte; must match the receiver.
DEPTH_LOG2, 2, FIFO depth = 2**DEPTH_LOG2 entries (4).
DROP_WHEN_FULL, 0, 0 = back-pressure the receiver when full; 1 = acknowledge and discard when full.

Ports:
clk  in  1  system clock.
rst  in  1  synchronous reset, active-high.
rx_valid  in  1  receiver holds a completed byte.
rx_data  in  PAYLOAD_BITS  receiver byte; stable while rx_valid.
rx_read  out  1  one-cycle acknowledge to receiver; receiver returns to idle.
rd_en  in  1  consumer pops head entry.
rd_data  out  PAYLOAD_BITS  head entry; valid only when rd_valid.
rd_valid  out  1  FIFO not empty.
level  out  DEPTH_LOG2+1  occupied entries, 0..DEPTH.
full  out  1  level == DEPTH.
overrun  out  1  sticky: a byte was discarded (DROP_WHEN_FULL=1 only).
clr_overrun  in  1  clears overrun.
flush  in  1  empties FIFO.
irq_thresh  in  DEPTH_LOG2+1  interrupt threshold.
irq  out  1  registered: level >= irq_thresh and irq_thresh != 0.

Behaviour:
- Storage: DEPTH x PAYLOAD_BITS register array; write and read pointers are DEPTH_LOG2 bits and wrap naturally; level is a separate counter.
- Reset (rst=1 at edge): pointers=0, level=0, rx_read=0, overrun=0, irq=0. rd_valid=0, full=0. Storage contents are not reset. rst overrides all other inputs.
- accept = rx_valid & ~rx_read & ~flush. The ~rx_read term prevents double capture while the receiver still shows valid during the ack cycle.
- push = accept & ~full: write rx_data at wptr, wptr+1.
- drop = accept & full & DROP_WHEN_FULL: no write; set overrun.
- rx_read is registered and equals push|drop of the previous cycle. It is a single-cycle pulse, one cycle after capture.
- DROP_WHEN_FULL=0 and full: no ack. The receiver holds its byte and keeps RTS deasserted. Capture proceeds in the first cycle after a pop makes room; there is no same-cycle full bypass.
- pop = rd_en & rd_valid & ~flush: rptr+1. rd_en while empty is ignored, with no underflow and level unchanged.
- Level update:
  - push & ~pop: level+1.
  - pop & ~push: level-1.
  - push & pop: unchanged.
- Empty with push and rd_en in the same cycle: the pop is ignored, the byte is stored, and level becomes 1.
- Latency: byte captured at edge N. In cycle N+1, rd_valid=1, rd_data=byte and rx_read=1.
- rd_data = mem[rptr] combinationally (FWFT). It updates in the cycle after a pop.
- flush: pointers=0, level=0, overrun=0. Any capture that cycle is suppressed and a pending byte is acked on a later cycle. flush has priority over push, pop and clr_overrun.
- overrun:
  - set by drop, clear by clr_overrun.
  - drop and clr_overrun in the same cycle: overrun is set (set wins).
  - never set when DROP_WHEN_FULL=0.
- irq is registered from the next-state level. It deasserts the cycle after level falls below the threshold. irq_thresh=0 disables irq.

Decomposition:
- Shared uart package: PAYLOAD_BITS default, depth constant and level width function; the receiver uses these too.
- One sub-module: tqvp_sync_fifo holds the generic storage, pointers and level with push/pop/flush.
- The top level adds the receiver handshake, drop/overrun logic and irq.

Test Plan:
- Reset then idle: rx_valid=0 -> rd_valid=0, level=0, rx_read=0, irq=0.
- Single byte 0xA5, rx_valid held 2 cycles -> exactly one rx_read pulse in the cycle after assertion; rd_data=0xA5, level=1. rd_en -> level=0, rd_valid=0.
- Push 0x01..0x04 (DROP=0), then present 0x05 -> full=1, rx_read stays 0. Pop once -> 0x05 captured next cycle, single rx_read. Drain order 0x02,0x03,0x04,0x05.
- DROP=1: fill 4, present 0x66 -> rx_read pulses, overrun=1, level=4, contents unchanged. clr_overrun together with another drop -> overrun stays 1.
- Pointer wrap: 10 push/pop pairs with simultaneous push+pop at level 2 -> level stays 2, data order preserved across the wrap.
- irq_thresh=3: push 3 bytes -> irq=1 after the third. Pop 1 -> irq=0 next cycle. flush at level 3 with rx_valid high -> level=0, no rx_read that cycle, byte captured the following cycle.
